fb_scan_reader: RTL and testbench
=================================

Name: fb_scan_reader

Overview:
- Parametrised, pipelined successor to the combinational frame-buffer address mapper.
- Converts the VGA controller's DrawX/DrawY into frame-buffer read addresses, aligns the returned data to the pixel stream, and blanks pixels outside the active area.
- Supports integer pixel up-scaling and double-buffered page flipping synchronised to vertical blank.
- Sits between the VGA controller, the frame-buffer RAM read port and the palette lookup.

Parameters:
- WIDTH, 640: active pixels per line.
- HEIGHT, 480: active lines per frame.
- SCALE_LOG2, 0: each stored pixel covers a 2^SCALE_LOG2 x 2^SCALE_LOG2 screen block.
- ADDR_W, 21: frame-buffer address width.
- COLOR_W, 8: colour-index width.
- MEM_LAT, 1: read latency of the frame-buffer RAM, in cycles (≥1).
- BG_COLOR, 0: colour index output for non-active pixels.

Ports:
- Clk  in  1  system/pixel clock.
- Reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current pixel column from the VGA controller.
- DrawY  in  10  current pixel row from the VGA controller.
- FB_DIN  in  COLOR_W  read data from the frame-buffer RAM.
- swap_req  in  1  one-cycle pulse requesting a page flip.
- FB_ADDR  out  ADDR_W  registered RAM read address.
- COLOR_ID  out  COLOR_W  aligned colour index.
- pix_valid  out  1  COLOR_ID comes from the frame buffer.
- display_page  out  1  page currently scanned out.
- draw_page  out  1  page the renderer may write; always ~display_page.
- swap_ack  out  1  one-cycle pulse when a flip takes effect.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. All registers clear on Reset.
- Reset values: FB_ADDR=0, COLOR_ID=BG_COLOR, pix_valid=0, display_page=0, draw_page=1, swap_ack=0, swap-pending flag=0. The alignment pipeline flushes to inactive.
- Derived constants:
  - SW = WIDTH>>SCALE_LOG2
  - SH = HEIGHT>>SCALE_LOG2
  - PAGE_SIZE = SW*SH
  - Page p base address = p*PAGE_SIZE.
- Stage A (cycle t, registered at end of t):
  - active = (DrawX<WIDTH) && (DrawY<HEIGHT).
  - If active: FB_ADDR = base(display_page) + (DrawX>>SCALE_LOG2) + (DrawY>>SCALE_LOG2)*SW, computed modulo 2^ADDR_W.
  - If not active: FB_ADDR = 0.
- Alignment: the active bit is delayed MEM_LAT cycles in a shift register. At cycle t+1+MEM_LAT:
  - pix_valid = delayed active.
  - COLOR_ID = FB_DIN (registered) when delayed active, else BG_COLOR.
- Total latency from DrawX/DrawY to COLOR_ID is 1+MEM_LAT cycles. Throughput is one pixel per clock with no stalls.
- Page flip state machine:
  - States: IDLE and PENDING.
  - swap_req=1 in IDLE moves to PENDING.
  - The flip point is the cycle where DrawY==HEIGHT && DrawX==0 (first blanking line).
  - At the flip point, if in PENDING or swap_req=1 that same cycle: toggle display_page, pulse swap_ack for exactly 1 cycle, return to IDLE.
  - swap_req while already in PENDING is absorbed: one flip per frame at most.
  - swap_req at the flip point while in IDLE flips immediately (same-cycle case).
  - The new display_page is used by stage A from the next cycle. Because the flip occurs in blanking, no active pixel mixes pages.
- Boundaries:
  - DrawX=WIDTH-1 and DrawY=HEIGHT-1 are active.
  - DrawX≥WIDTH or DrawY≥HEIGHT gives pix_valid=0.
  - DrawX/DrawY wrap freely; no internal frame counter.
  - Reset asserted mid-frame clears a pending flip; display returns to page 0.

Optional Feature:
- Macro: FB_PAGE_FLIP_EN.
- Defined: double buffering as described above.
- Undefined:
  - Single page; base is always 0.
  - display_page=0 and draw_page=0 constant.
  - swap_req is ignored; swap_ack is tied to 0.
  - No flip state machine is built.

Test Plan:
- Defaults, MEM_LAT=1, model RAM returning addr[7:0]; DrawX=5, DrawY=2 → FB_ADDR=1285 after 1 cycle; COLOR_ID=0x05, pix_valid=1 after 2 cycles.
- SCALE_LOG2=1; DrawX=5, DrawY=3 → FB_ADDR=2+1*320=322; DrawX=639, DrawY=479 → FB_ADDR=319+239*320=76799.
- DrawX=700, DrawY=10 → FB_ADDR=0, pix_valid=0, COLOR_ID=BG_COLOR at latency 2.
- FB_PAGE_FLIP_EN: pulse swap_req mid-frame at DrawY=100 → no change until DrawY=480, DrawX=0; then swap_ack high for 1 cycle, display_page=1, draw_page=0; next frame DrawX=0, DrawY=0 → FB_ADDR=307200.
- Pulse swap_req twice in one frame → exactly one flip and one swap_ack. Assert Reset mid-frame with a pending flip → no flip; display_page=0.
- MEM_LAT=3 → COLOR_ID and pix_valid appear 4 cycles after DrawX/DrawY, aligned for a continuous 640-pixel line sweep.

Source files
------------

// File: rtl/fb_scan_reader.sv
// fb_scan_reader
//   Pipelined frame-buffer scan-out reader. Maps the VGA controller's
//   DrawX/DrawY to a registered frame-buffer read address, realigns the
//   returned colour index with the pixel stream, and blanks pixels that are
//   outside the active area. It supports integer up-scaling by 2^SCALE_LOG2.
//   With FB_PAGE_FLIP_EN defined, it also supports double-buffered page
//   flipping at the start of vertical blank.
//
//   Latency DrawX/DrawY -> COLOR_ID/pix_valid is 1+MEM_LAT cycles, one pixel
//   per clock, no stalls.
//
// Ports
//   Clk           in   pixel/system clock
//   Reset         in   asynchronous active-high reset
//   DrawX, DrawY  in   [9:0] current pixel column/row
//   FB_DIN        in   [COLOR_W-1:0] frame-buffer read data
//   swap_req      in   one-cycle page-flip request
//   FB_ADDR       out  [ADDR_W-1:0] registered read address
//   COLOR_ID      out  [COLOR_W-1:0] aligned colour index (BG_COLOR if blank)
//   pix_valid     out  COLOR_ID came from the frame buffer
//   display_page  out  page being scanned out
//   draw_page     out  page the renderer may write (~display_page)
//   swap_ack      out  one-cycle pulse when a flip takes effect
//
// Build option
//   FB_PAGE_FLIP_EN  defined: two pages with a vblank-synchronised flip FSM.
//                    undefined: single page at base 0; swap_req is ignored,
//                    and the page outputs and swap_ack are tied to 0.

module fb_scan_reader #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int SCALE_LOG2 = 0,
  parameter int ADDR_W     = 21,
  parameter int COLOR_W    = 8,
  parameter int MEM_LAT    = 1,
  parameter int BG_COLOR   = 0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic [COLOR_W-1:0] FB_DIN,
  input  logic               swap_req,
  output logic [ADDR_W-1:0]  FB_ADDR,
  output logic [COLOR_W-1:0] COLOR_ID,
  output logic               pix_valid,
  output logic               display_page,
  output logic               draw_page,
  output logic               swap_ack
);

  localparam int SW        = WIDTH  >> SCALE_LOG2;
  localparam int SH        = HEIGHT >> SCALE_LOG2;
  localparam int PAGE_SIZE = SW * SH;

  // Widen the coordinates once so that every compare and product is a
  // 32-bit operation.
  logic [31:0] x32, y32;
  logic        active;
  logic [31:0] base, lin;

  assign x32    = 32'(DrawX);
  assign y32    = 32'(DrawY);
  assign active = (x32 < 32'(WIDTH)) && (y32 < 32'(HEIGHT));
  assign base   = display_page ? 32'(PAGE_SIZE) : 32'd0;

  // The address wraps modulo 2^ADDR_W through the truncation below.
  always_comb begin
    lin = base + (x32 >> SCALE_LOG2) + (y32 >> SCALE_LOG2) * 32'(SW);
  end

  // Stage A: register the address. Its active bit enters the alignment pipe.
  // vld_pipe[0] sits beside FB_ADDR. vld_pipe[MEM_LAT-1] lines up with
  // FB_DIN, because the RAM returns data MEM_LAT-1 cycles after the address
  // register.
  logic [MEM_LAT-1:0] vld_pipe;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      FB_ADDR  <= '0;
      vld_pipe <= '0;
    end else begin
      FB_ADDR     <= active ? lin[ADDR_W-1:0] : '0;
      vld_pipe[0] <= active;
      for (int i = 1; i < MEM_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Output register: capture the RAM data, or substitute the background.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      COLOR_ID  <= COLOR_W'(BG_COLOR);
      pix_valid <= 1'b0;
    end else begin
      COLOR_ID  <= vld_pipe[MEM_LAT-1] ? FB_DIN : COLOR_W'(BG_COLOR);
      pix_valid <= vld_pipe[MEM_LAT-1];
    end
  end

`ifdef FB_PAGE_FLIP_EN
  typedef enum logic {IDLE, PENDING} flip_state_t;
  flip_state_t state;
  logic        flip_pt;

  // The first pixel of the first blanking line. No active pixel is in
  // flight through stage A at this point, so a flip cannot tear a frame.
  assign flip_pt = (y32 == 32'(HEIGHT)) && (x32 == 32'd0);

  // A request that arrives on the flip point is honoured at once. Extra
  // requests while PENDING merge into the single pending flip.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      display_page <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (flip_pt && (state == PENDING || swap_req)) begin
        display_page <= ~display_page;
        swap_ack     <= 1'b1;
        state        <= IDLE;
      end else if (swap_req) begin
        state <= PENDING;
      end
    end
  end

  assign draw_page = ~display_page;
`else
  logic unused_swap;
  assign unused_swap  = swap_req;
  assign display_page = 1'b0;
  assign draw_page    = 1'b0;
  assign swap_ack     = 1'b0;
`endif

endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed bench for fb_scan_reader. Three instances share the raster
// inputs:
//   u0: default parameters (MEM_LAT=1)
//   u1: SCALE_LOG2=1
//   u3: MEM_LAT=3, BG_COLOR=0x3C
// Each frame-buffer model returns addr[7:0] with the matching read latency.
module tb_fb_scan_reader;
  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] DrawX, DrawY;
  logic       swap_req;

  logic [20:0] addr0, addr1, addr3;
  logic [7:0]  din0, din1, din3, col0, col1, col3;
  logic        pv0, pv1, pv3, dp0, dp1, dp3, drp0, drp1, drp3, ack0, ack1, ack3;
  logic [7:0]  r1, r2;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  // Both MEM_LAT=1 RAMs are combinational on the registered address. The
  // MEM_LAT=3 RAM adds two registers.
  assign din0 = addr0[7:0];
  assign din1 = addr1[7:0];
  always @(posedge Clk) begin
    r1 <= addr3[7:0];
    r2 <= r1;
  end
  assign din3 = r2;

  fb_scan_reader u0 (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .FB_DIN(din0),
    .swap_req(swap_req), .FB_ADDR(addr0), .COLOR_ID(col0), .pix_valid(pv0),
    .display_page(dp0), .draw_page(drp0), .swap_ack(ack0));

  fb_scan_reader #(.SCALE_LOG2(1)) u1 (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .FB_DIN(din1),
    .swap_req(swap_req), .FB_ADDR(addr1), .COLOR_ID(col1), .pix_valid(pv1),
    .display_page(dp1), .draw_page(drp1), .swap_ack(ack1));

  fb_scan_reader #(.MEM_LAT(3), .BG_COLOR(8'h3C)) u3 (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .FB_DIN(din3),
    .swap_req(swap_req), .FB_ADDR(addr3), .COLOR_ID(col3), .pix_valid(pv3),
    .display_page(dp3), .draw_page(drp3), .swap_ack(ack3));

  // Advance one clock and settle 1 ns past the edge. Inputs change and
  // outputs are sampled at that point.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic exp_drp;
`ifdef FB_PAGE_FLIP_EN
    exp_drp = 1'b1;
`else
    exp_drp = 1'b0;
`endif
    DrawX = 10'd5; DrawY = 10'd2; swap_req = 1'b0; Reset = 1'b0;
    step(); step(); step();
    // Reset is asynchronous, so the check comes before any clock edge.
    Reset = 1'b1;
    #2;
    total++; if (addr0 !== 21'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", addr0); end
    total++; if (col0 !== 8'h00) begin bad++; $display("FAIL reset_color got=%0h want=0", col0); end
    total++; if (col3 !== 8'h3C) begin bad++; $display("FAIL reset_color_bg got=%0h want=3c", col3); end
    total++; if (pv0 !== 1'b0 || pv3 !== 1'b0) begin bad++; $display("FAIL reset_pv got=%b%b want=00", pv0, pv3); end
    total++; if (dp0 !== 1'b0 || drp0 !== exp_drp || ack0 !== 1'b0)
      begin bad++; $display("FAIL reset_pages got dp=%b drp=%b ack=%b want dp=0 drp=%b ack=0", dp0, drp0, ack0, exp_drp); end
    step();
    Reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    do_reset();
    DrawX = 10'd5; DrawY = 10'd2;
    step();
    total++; if (addr0 !== 21'd1285) begin bad++; $display("FAIL basic_addr got=%0d want=1285", addr0); end
    DrawX = 10'd700; DrawY = 10'd10;
    step();
    total++; if (col0 !== 8'h05 || pv0 !== 1'b1) begin bad++; $display("FAIL basic_color got=%0h/%b want=05/1", col0, pv0); end
    total++; if (addr0 !== 21'd0) begin bad++; $display("FAIL blank_addr got=%0d want=0", addr0); end
    DrawX = 10'd639; DrawY = 10'd479;
    step();
    total++; if (col0 !== 8'h00 || pv0 !== 1'b0) begin bad++; $display("FAIL blank_color got=%0h/%b want=00/0", col0, pv0); end
    total++; if (addr0 !== 21'd307199) begin bad++; $display("FAIL corner_addr got=%0d want=307199", addr0); end
    DrawX = 10'd640; DrawY = 10'd0;
    step();
    total++; if (col0 !== 8'hFF || pv0 !== 1'b1) begin bad++; $display("FAIL corner_color got=%0h/%b want=ff/1", col0, pv0); end
    DrawX = 10'd0; DrawY = 10'd480;
    step();
    total++; if (pv0 !== 1'b0 || addr0 !== 21'd0) begin bad++; $display("FAIL x640 got pv=%b addr=%0d want 0/0", pv0, addr0); end
    DrawX = 10'd1023; DrawY = 10'd1023;
    step();
    total++; if (pv0 !== 1'b0 || addr0 !== 21'd0) begin bad++; $display("FAIL y480 got pv=%b addr=%0d want 0/0", pv0, addr0); end
    step();
    total++; if (pv0 !== 1'b0 || col0 !== 8'h00) begin bad++; $display("FAIL max_xy got pv=%b col=%0h want 0/00", pv0, col0); end
  endtask

  task automatic test_scale();
    do_reset();
    DrawX = 10'd5; DrawY = 10'd3;
    step();
    total++; if (addr1 !== 21'd322) begin bad++; $display("FAIL scale_addr got=%0d want=322", addr1); end
    DrawX = 10'd639; DrawY = 10'd479;
    step();
    total++; if (col1 !== 8'd66 || pv1 !== 1'b1) begin bad++; $display("FAIL scale_color got=%0d/%b want=66/1", col1, pv1); end
    total++; if (addr1 !== 21'd76799) begin bad++; $display("FAIL scale_corner got=%0d want=76799", addr1); end
  endtask

  // A continuous line sweep through the MEM_LAT=3 instance. Outputs must
  // trail the inputs by exactly 4 cycles, including the active-to-blank edge
  // at x=640.
  task automatic test_back_to_back();
    int xs;
    logic [7:0] ec;
    logic       ev;
    do_reset();
    DrawY = 10'd7;
    for (int c = 0; c < 660; c++) begin
      DrawX = 10'(c);
      step();
      if (c >= 3) begin
        xs = c - 3;
        ev = (xs < 640);
        ec = ev ? 8'((xs + 4480) & 255) : 8'h3C;
        total++;
        if (col3 !== ec || pv3 !== ev) begin
          bad++;
          $display("FAIL sweep x=%0d got=%0h/%b want=%0h/%b", xs, col3, pv3, ec, ev);
        end
      end
    end
  endtask

`ifdef FB_PAGE_FLIP_EN
  task automatic test_flip();
    int acks;
    do_reset();
    DrawY = 10'd100; DrawX = 10'd3; swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    total++; if (dp0 !== 1'b0 || ack0 !== 1'b0) begin bad++; $display("FAIL flip_early got dp=%b ack=%b want 0/0", dp0, ack0); end
    DrawY = 10'd479; DrawX = 10'd639;
    step();
    total++; if (dp0 !== 1'b0) begin bad++; $display("FAIL flip_wait got=%b want=0", dp0); end
    DrawY = 10'd480; DrawX = 10'd0;
    step();
    total++; if (dp0 !== 1'b1 || drp0 !== 1'b0 || ack0 !== 1'b1)
      begin bad++; $display("FAIL flip_take got dp=%b drp=%b ack=%b want 1/0/1", dp0, drp0, ack0); end
    DrawX = 10'd1;
    step();
    total++; if (ack0 !== 1'b0 || dp0 !== 1'b1) begin bad++; $display("FAIL flip_ack_pulse got ack=%b dp=%b want 0/1", ack0, dp0); end
    DrawX = 10'd0; DrawY = 10'd0;
    step();
    total++; if (addr0 !== 21'd307200) begin bad++; $display("FAIL flip_base got=%0d want=307200", addr0); end

    // Two requests in one frame produce a single flip.
    acks = 0;
    DrawY = 10'd50; swap_req = 1'b1; step(); swap_req = 1'b0;
    DrawY = 10'd60; swap_req = 1'b1; step(); swap_req = 1'b0;
    DrawY = 10'd480; DrawX = 10'd0; step(); acks += int'(ack0);
    DrawX = 10'd1; step(); acks += int'(ack0);
    DrawY = 10'd0; DrawX = 10'd0; step();
    DrawY = 10'd480; step(); acks += int'(ack0);
    total++; if (acks != 1 || dp0 !== 1'b0) begin bad++; $display("FAIL flip_double got acks=%0d dp=%b want 1/0", acks, dp0); end

    // A request on the flip point itself while IDLE flips immediately.
    DrawX = 10'd5; step();
    DrawX = 10'd0; swap_req = 1'b1; step(); swap_req = 1'b0;
    total++; if (dp0 !== 1'b1 || ack0 !== 1'b1) begin bad++; $display("FAIL flip_same got dp=%b ack=%b want 1/1", dp0, ack0); end

    // A reset while a flip is pending cancels the flip.
    DrawY = 10'd200; DrawX = 10'd9; swap_req = 1'b1; step(); swap_req = 1'b0;
    Reset = 1'b1; step(); Reset = 1'b0; step();
    total++; if (dp0 !== 1'b0) begin bad++; $display("FAIL flip_reset_page got=%b want=0", dp0); end
    DrawY = 10'd480; DrawX = 10'd0; step();
    total++; if (dp0 !== 1'b0 || ack0 !== 1'b0) begin bad++; $display("FAIL flip_reset_cancel got dp=%b ack=%b want 0/0", dp0, ack0); end
  endtask
`else
  task automatic test_single_page();
    do_reset();
    DrawY = 10'd100; DrawX = 10'd3; swap_req = 1'b1; step(); swap_req = 1'b0;
    DrawY = 10'd480; DrawX = 10'd0; swap_req = 1'b1; step(); swap_req = 1'b0;
    total++; if (dp0 !== 1'b0 || drp0 !== 1'b0 || ack0 !== 1'b0)
      begin bad++; $display("FAIL single_page got dp=%b drp=%b ack=%b want 0/0/0", dp0, drp0, ack0); end
    DrawY = 10'd0; DrawX = 10'd0; step();
    total++; if (addr0 !== 21'd0 || ack0 !== 1'b0) begin bad++; $display("FAIL single_base got addr=%0d ack=%b want 0/0", addr0, ack0); end
  endtask
`endif

  initial begin
    Reset = 1'b1; DrawX = '0; DrawY = '0; swap_req = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_scale();
    test_back_to_back();
`ifdef FB_PAGE_FLIP_EN
    test_flip();
`else
    test_single_page();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
